// File: rtl/mio_bus_responder.sv
// mio_bus_responder: memory/IO-side responder for the CPU data port.
// Serves one word request at a time from data RAM, an LED register or a
// free-running cycle counter, completing with a one-cycle mio_ready pulse
// after WAIT_STATES wait cycles.
// Optional feature macro: MIO_ERR_EN adds the mio_err output, flagging
// unmapped accesses and writes to the read-only counter.
module mio_bus_responder #(
    parameter int RAM_AW      = 10,
    parameter int WAIT_STATES = 1,
    parameter int LED_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cpu_mio,
    input  logic             mem_w,
    input  logic [31:0]      addr,
    input  logic [31:0]      data_wr,
    output logic [31:0]      data_rd,
    output logic             mio_ready,
`ifdef MIO_ERR_EN
    output logic             mio_err,
`endif
    output logic [LED_W-1:0] led_out
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam logic [3:0] REGION_RAM = 4'h0;
    localparam logic [3:0] REGION_LED = 4'hE;
    localparam logic [3:0] REGION_CNT = 4'hF;

    state_t              r_state;
    logic [3:0]          r_region;
    logic [RAM_AW-1:0]   r_idx;
    logic                r_we;
    logic [31:0]         r_wdata;
    logic [3:0]          r_wait;
    logic [31:0]         r_cnt;
    logic [LED_W-1:0]    r_led;
    logic [31:0]         r_dataRd;
    logic                r_ready;
    logic [31:0]         r_ram [0:(1<<RAM_AW)-1];

    logic [3:0]          w_decRegion;
    logic [RAM_AW-1:0]   w_decIdx;
    logic                w_decWe;
    logic [31:0]         w_rdData;
    logic [31:0]         w_respData;
    logic                w_unused;

`ifdef MIO_ERR_EN
    logic                r_err;
    logic                w_err;
`endif

    // Address bits below the region field and above the RAM index alias away.
    assign w_unused = &{1'b0, addr[27:RAM_AW+2], addr[1:0]};

    // Decode the transaction being answered: the live request when it goes
    // straight from IDLE to RESP, otherwise the latched one.
    always_comb begin
        w_decRegion = r_region;
        w_decIdx    = r_idx;
        w_decWe     = r_we;
        if (r_state == IDLE) begin
            w_decRegion = addr[31:28];
            w_decIdx    = addr[RAM_AW+1:2];
            w_decWe     = mem_w;
        end
        w_rdData = '0;
        case (w_decRegion)
            REGION_RAM: w_rdData = r_ram[w_decIdx];
            REGION_LED: w_rdData = 32'(r_led);
            REGION_CNT: w_rdData = r_cnt;
            default:    w_rdData = '0;
        endcase
        w_respData = w_decWe ? '0 : w_rdData;
`ifdef MIO_ERR_EN
        case (w_decRegion)
            REGION_RAM: w_err = 1'b0;
            REGION_LED: w_err = 1'b0;
            REGION_CNT: w_err = w_decWe;
            default:    w_err = 1'b1;
        endcase
`endif
    end

    // Request FSM with registered response outputs, LED register and counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_region <= '0;
            r_idx    <= '0;
            r_we     <= 1'b0;
            r_wdata  <= '0;
            r_wait   <= '0;
            r_cnt    <= '0;
            r_led    <= '0;
            r_dataRd <= '0;
            r_ready  <= 1'b0;
`ifdef MIO_ERR_EN
            r_err    <= 1'b0;
`endif
        end else begin
            r_cnt    <= r_cnt + 32'd1;
            r_ready  <= 1'b0;
            r_dataRd <= '0;
`ifdef MIO_ERR_EN
            r_err    <= 1'b0;
`endif
            case (r_state)
                IDLE: begin
                    if (cpu_mio) begin
                        r_region <= addr[31:28];
                        r_idx    <= addr[RAM_AW+1:2];
                        r_we     <= mem_w;
                        r_wdata  <= data_wr;
                        if (WAIT_STATES == 0) begin
                            r_state  <= RESP;
                            r_ready  <= 1'b1;
                            r_dataRd <= w_respData;
`ifdef MIO_ERR_EN
                            r_err    <= w_err;
`endif
                        end else begin
                            r_wait  <= 4'(WAIT_STATES);
                            r_state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    r_wait <= r_wait - 4'd1;
                    if (r_wait <= 4'd1) begin
                        r_state  <= RESP;
                        r_ready  <= 1'b1;
                        r_dataRd <= w_respData;
`ifdef MIO_ERR_EN
                        r_err    <= w_err;
`endif
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                    if (r_we && (r_region == REGION_LED)) begin
                        r_led <= r_wdata[LED_W-1:0];
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // RAM write commits as the write leaves RESP; a reset on that edge drops it.
    always_ff @(posedge clk) begin
        if (!reset && (r_state == RESP) && r_we && (r_region == REGION_RAM)) begin
            r_ram[r_idx] <= r_wdata;
        end
    end

    assign data_rd   = r_dataRd;
    assign mio_ready = r_ready;
    assign led_out   = r_led;
`ifdef MIO_ERR_EN
    assign mio_err   = r_err;
`endif

endmodule

// File: tb/tb_mio_bus_responder.sv
// tb_mio_bus_responder: directed bench for mio_bus_responder.
// Instance A uses WAIT_STATES=1, instance B uses WAIT_STATES=3.
module tb_mio_bus_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;

    logic        aMio = 1'b0;
    logic        aWe = 1'b0;
    logic [31:0] aAddr = '0;
    logic [31:0] aWdata = '0;
    logic [31:0] aRd;
    logic        aReady;
    logic [15:0] aLed;

    logic        bMio = 1'b0;
    logic        bWe = 1'b0;
    logic [31:0] bAddr = '0;
    logic [31:0] bWdata = '0;
    logic [31:0] bRd;
    logic        bReady;
    logic [15:0] bLed;

`ifdef MIO_ERR_EN
    logic        aErr;
    logic        bErr;
`endif

    int checkCount = 0;
    int errorCount = 0;

    // Free-running clock, 10 ns period.
    always #5 clk = ~clk;

    mio_bus_responder #(.RAM_AW(10), .WAIT_STATES(1), .LED_W(16)) dutA (
        .clk       (clk),
        .reset     (reset),
        .cpu_mio   (aMio),
        .mem_w     (aWe),
        .addr      (aAddr),
        .data_wr   (aWdata),
        .data_rd   (aRd),
        .mio_ready (aReady),
`ifdef MIO_ERR_EN
        .mio_err   (aErr),
`endif
        .led_out   (aLed)
    );

    mio_bus_responder #(.RAM_AW(10), .WAIT_STATES(3), .LED_W(16)) dutB (
        .clk       (clk),
        .reset     (reset),
        .cpu_mio   (bMio),
        .mem_w     (bWe),
        .addr      (bAddr),
        .data_wr   (bWdata),
        .data_rd   (bRd),
        .mio_ready (bReady),
`ifdef MIO_ERR_EN
        .mio_err   (bErr),
`endif
        .led_out   (bLed)
    );

    // Advance one cycle and settle just after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Count one comparison and report it if the values differ.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // One transaction on instance A; request dropped right at the ready pulse.
    task automatic applyStimulus(input string tag, input logic we, input logic [31:0] ad,
                                 input logic [31:0] wd, input logic expErr,
                                 output logic [31:0] rd);
        aMio = 1'b1; aWe = we; aAddr = ad; aWdata = wd;
        tick();
        checkOutput({tag, "_c1_ready"}, 32'(aReady), 32'd0);
        tick();
        checkOutput({tag, "_c2_ready"}, 32'(aReady), 32'd1);
        rd = aRd;
`ifdef MIO_ERR_EN
        checkOutput({tag, "_err"}, 32'(aErr), 32'(expErr));
`else
        if (expErr) begin end
`endif
        aMio = 1'b0; aWe = 1'b0; aAddr = '0; aWdata = '0;
        tick();
        checkOutput({tag, "_c3_ready"}, 32'(aReady), 32'd0);
        checkOutput({tag, "_c3_rd"}, aRd, 32'd0);
    endtask

    logic [31:0] rdVal;
    logic [31:0] cntA;
    logic [31:0] cntB;

    initial begin
        $display("[TB] start");
        repeat (3) tick();
        checkOutput("rst_readyA", 32'(aReady), 32'd0);
        checkOutput("rst_rdA", aRd, 32'd0);
        checkOutput("rst_ledA", 32'(aLed), 32'd0);
        checkOutput("rst_readyB", 32'(bReady), 32'd0);
        reset = 1'b0;
        tick();

        // RAM write, read-back and aliasing
        applyStimulus("ramWr", 1'b1, 32'h0000_0010, 32'h1234_5678, 1'b0, rdVal);
        checkOutput("ramWr_data", rdVal, 32'd0);
        applyStimulus("ramRd", 1'b0, 32'h0000_0010, 32'h0, 1'b0, rdVal);
        checkOutput("ramRd_data", rdVal, 32'h1234_5678);
        applyStimulus("ramAlias", 1'b0, 32'h0000_1010, 32'h0, 1'b0, rdVal);
        checkOutput("ramAlias_data", rdVal, 32'h1234_5678);

        // LED write and zero-extended read
        applyStimulus("ledWr", 1'b1, 32'hE000_0000, 32'hFFFF_ABCD, 1'b0, rdVal);
        checkOutput("ledWr_led", 32'(aLed), 32'h0000_ABCD);
        applyStimulus("ledRd", 1'b0, 32'hE000_0000, 32'h0, 1'b0, rdVal);
        checkOutput("ledRd_data", rdVal, 32'h0000_ABCD);

        // Unmapped region reads zero and does not alias into RAM
        applyStimulus("unmapRd", 1'b0, 32'h5000_0010, 32'h0, 1'b1, rdVal);
        checkOutput("unmapRd_data", rdVal, 32'd0);
        applyStimulus("cntWr", 1'b1, 32'hF000_0000, 32'h0000_0000, 1'b1, rdVal);
        checkOutput("cntWr_data", rdVal, 32'd0);

        // Back-to-back counter reads with the request held high
        aMio = 1'b1; aWe = 1'b0; aAddr = 32'hF000_0000;
        tick();
        tick();
        checkOutput("b2b_ready1", 32'(aReady), 32'd1);
        cntA = aRd;
        tick();
        checkOutput("b2b_gap", 32'(aReady), 32'd0);
        tick();
        tick();
        checkOutput("b2b_ready2", 32'(aReady), 32'd1);
        cntB = aRd;
        aMio = 1'b0;
        checkOutput("b2b_delta", cntB - cntA, 32'd3);
        tick();

        // Reset during WAIT drops the pending write
        applyStimulus("oldWr", 1'b1, 32'h0000_0020, 32'hCAFE_0020, 1'b0, rdVal);
        aMio = 1'b1; aWe = 1'b1; aAddr = 32'h0000_0020; aWdata = 32'hDEAD_0001;
        tick();
        reset = 1'b1; aMio = 1'b0;
        tick();
        checkOutput("rstWait_ready1", 32'(aReady), 32'd0);
        reset = 1'b0;
        tick();
        checkOutput("rstWait_ready2", 32'(aReady), 32'd0);
        checkOutput("rstWait_led", 32'(aLed), 32'd0);
        applyStimulus("rstWaitRd", 1'b0, 32'h0000_0020, 32'h0, 1'b0, rdVal);
        checkOutput("rstWaitRd_data", rdVal, 32'hCAFE_0020);

        // Instance B: request withdrawn after one cycle, inputs scrambled
        bMio = 1'b1; bWe = 1'b1; bAddr = 32'hE000_0000; bWdata = 32'h0000_5A5A;
        tick();
        bMio = 1'b0; bWe = 1'b0; bAddr = 32'h0000_0000; bWdata = 32'h0000_FFFF;
        checkOutput("wd_c1", 32'(bReady), 32'd0);
        tick();
        checkOutput("wd_c2", 32'(bReady), 32'd0);
        tick();
        checkOutput("wd_c3", 32'(bReady), 32'd0);
        tick();
        checkOutput("wd_c4", 32'(bReady), 32'd1);
        checkOutput("wd_c4_rd", bRd, 32'd0);
        for (int i = 5; i < 10; i++) begin
            tick();
            checkOutput($sformatf("wd_c%0d", i), 32'(bReady), 32'd0);
        end
        checkOutput("wd_led", 32'(bLed), 32'h0000_5A5A);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
